// File: rtl/conv_pkg.sv
// Shared constants and helpers for the convolution pipeline: line buffer,
// window control and MAC stages.
package conv_pkg;

  localparam int unsigned DATA_SIZE_DEF   = 32;
  localparam int unsigned KERNEL_SIZE_DEF = 5;
  localparam int unsigned PIX_W_DEF       = 8;
  localparam int unsigned STRIDE_DEF      = 1;

  // Never returns 0, so a value of 1 still yields a legal 1-bit vector.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((32'd1 << width) < value) width++;
    return width;
  endfunction

  // Bit offset of window element (r,c); r=0 is the top row, c=0 the leftmost column.
  function automatic int unsigned win_off(input int unsigned r, input int unsigned c,
                                          input int unsigned k, input int unsigned w);
    return (r * k + c) * w;
  endfunction

endpackage

// File: rtl/conv_line_buffer_if.sv
// Pixel-in / window-out handshake bundle for conv_line_buffer.
// CONV_LB_EOL_CHECK_EN adds s_eol (end-of-line marker) and o_err (sticky line-length error).
interface conv_line_buffer_if
  import conv_pkg::*;
#(
  parameter int unsigned PIX_W       = PIX_W_DEF,
  parameter int unsigned KERNEL_SIZE = KERNEL_SIZE_DEF
);
  localparam int unsigned WIN_W = KERNEL_SIZE * KERNEL_SIZE * PIX_W;

  logic             s_valid;
  logic             s_ready;
  logic [PIX_W-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIN_W-1:0] m_window;
  logic             m_last;
`ifdef CONV_LB_EOL_CHECK_EN
  logic             s_eol;
  logic             o_err;

  modport master (output s_valid, s_data, s_eol, m_ready,
                  input  s_ready, m_valid, m_window, m_last, o_err);
  modport slave  (input  s_valid, s_data, s_eol, m_ready,
                  output s_ready, m_valid, m_window, m_last, o_err);
`else
  modport master (output s_valid, s_data, m_ready,
                  input  s_ready, m_valid, m_window, m_last);
  modport slave  (input  s_valid, s_data, m_ready,
                  output s_ready, m_valid, m_window, m_last);
`endif
endinterface

// File: rtl/conv_line_mem.sv
// One image-row delay line indexed by column; read-before-write in the same cycle.
module conv_line_mem #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned W     = 8,
  parameter int unsigned AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/conv_line_buffer.sv
// Raster pixel stream to KERNEL_SIZE x KERNEL_SIZE sliding window with stride and end-of-frame flag.
// CONV_LB_EOL_CHECK_EN enables s_eol resync and the sticky o_err line-length check.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int unsigned DATA_SIZE   = DATA_SIZE_DEF,
  parameter int unsigned KERNEL_SIZE = KERNEL_SIZE_DEF,
  parameter int unsigned PIX_W       = PIX_W_DEF,
  parameter int unsigned STRIDE      = STRIDE_DEF
) (
  input logic               clk,
  input logic               rst_n,
  conv_line_buffer_if.slave bus
);
  localparam int unsigned   CW       = clog2(DATA_SIZE);
  localparam int unsigned   PW       = clog2(STRIDE);
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_SIZE - 1);
  localparam logic [CW-1:0] K_M1     = CW'(KERNEL_SIZE - 1);
  localparam logic [PW-1:0] PH_MAX   = PW'(STRIDE - 1);

  logic [CW-1:0]    row, col;
  logic [PW-1:0]    row_ph, col_ph;
  logic             m_valid_q, m_last_q;
  logic             accept, complete, frame_end, row_end;
  logic [PIX_W-1:0] win     [KERNEL_SIZE][KERNEL_SIZE];
  logic [PIX_W-1:0] rd      [KERNEL_SIZE-1];
  logic [PIX_W-1:0] col_new [KERNEL_SIZE];

  assign bus.s_ready = !m_valid_q || bus.m_ready;
  assign accept      = bus.s_valid && bus.s_ready;
  // Phases only advance once the axis reaches K-1, so phase 0 means stride-aligned.
  assign complete    = (row >= K_M1) && (col >= K_M1) && (row_ph == '0) && (col_ph == '0);
  assign frame_end   = (row == LAST_IDX) && (col == LAST_IDX);
`ifdef CONV_LB_EOL_CHECK_EN
  assign row_end     = (col == LAST_IDX) || bus.s_eol;
`else
  assign row_end     = (col == LAST_IDX);
`endif

  for (genvar k = 0; k < KERNEL_SIZE - 1; k++) begin : g_line
    logic [PIX_W-1:0] wdata;
    if (k == 0) begin : g_head
      assign wdata = bus.s_data;
    end else begin : g_chain
      assign wdata = rd[k-1];
    end
    conv_line_mem #(.DEPTH(DATA_SIZE), .W(PIX_W), .AW(CW)) u_mem (
      .clk   (clk),
      .we    (accept),
      .addr  (col),
      .wdata (wdata),
      .rdata (rd[k])
    );
  end

  // Deepest line memory holds the oldest row, which lands at the top of the window.
  always_comb begin
    for (int unsigned r = 0; r < KERNEL_SIZE - 1; r++) col_new[r] = rd[KERNEL_SIZE-2-r];
    col_new[KERNEL_SIZE-1] = bus.s_data;
  end

  always_comb begin
    bus.m_window = '0;
    for (int unsigned r = 0; r < KERNEL_SIZE; r++)
      for (int unsigned c = 0; c < KERNEL_SIZE; c++)
        bus.m_window[win_off(r, c, KERNEL_SIZE, PIX_W) +: PIX_W] = win[r][c];
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_last  = m_last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < KERNEL_SIZE; r++)
        for (int unsigned c = 0; c < KERNEL_SIZE; c++) win[r][c] <= '0;
    end else if (accept) begin
      for (int unsigned r = 0; r < KERNEL_SIZE; r++) begin
        for (int unsigned c = 0; c < KERNEL_SIZE - 1; c++) win[r][c] <= win[r][c+1];
        win[r][KERNEL_SIZE-1] <= col_new[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row       <= '0;
      col       <= '0;
      row_ph    <= '0;
      col_ph    <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else if (accept) begin
      m_valid_q <= complete;
      m_last_q  <= complete && frame_end;
      if (frame_end) begin
        row    <= '0;
        col    <= '0;
        row_ph <= '0;
        col_ph <= '0;
      end else if (row_end) begin
        col    <= '0;
        col_ph <= '0;
        row    <= row + CW'(1);
        if (row >= K_M1) row_ph <= (row_ph == PH_MAX) ? '0 : row_ph + PW'(1);
      end else begin
        col <= col + CW'(1);
        if (col >= K_M1) col_ph <= (col_ph == PH_MAX) ? '0 : col_ph + PW'(1);
      end
    end else if (bus.m_ready) begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end
  end

`ifdef CONV_LB_EOL_CHECK_EN
  logic o_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       o_err_q <= 1'b0;
    else if (accept && (bus.s_eol != (col == LAST_IDX))) o_err_q <= 1'b1;
  end

  assign bus.o_err = o_err_q;
`endif
endmodule

// File: tb/tb_conv_line_buffer.sv
// Scoreboard bench for conv_line_buffer: a STRIDE=1 and a STRIDE=2 instance see the same
// accepted pixel stream and are checked against a column-history window model.
module tb_conv_line_buffer;
  localparam int D  = 32;
  localparam int K  = 5;
  localparam int W  = 8;
  localparam int WW = K * K * W;
`ifdef CONV_LB_EOL_CHECK_EN
  localparam bit EOL_EN = 1'b1;
`else
  localparam bit EOL_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  conv_line_buffer_if #(.PIX_W(W), .KERNEL_SIZE(K)) bus ();
  conv_line_buffer_if #(.PIX_W(W), .KERNEL_SIZE(K)) bus2 ();

  assign bus2.s_valid = bus.s_valid && bus.s_ready;
  assign bus2.s_data  = bus.s_data;
  assign bus2.m_ready = 1'b1;
`ifdef CONV_LB_EOL_CHECK_EN
  assign bus2.s_eol   = bus.s_eol;
`endif

  conv_line_buffer #(.DATA_SIZE(D), .KERNEL_SIZE(K), .PIX_W(W), .STRIDE(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  conv_line_buffer #(.DATA_SIZE(D), .KERNEL_SIZE(K), .PIX_W(W), .STRIDE(2)) dut_s2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  typedef struct {
    logic [WW-1:0] win;
    logic          last;
    int            cyc;
  } exp_t;

  exp_t          exp_q [2][$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [7:0]    colhist [D][K];
  int            mrow = 0;
  int            mcol = 0;
  bit            exp_err = 1'b0;
  int            err_cyc = 0;
  int            popped [2];
  bit            hold [2];
  logic [WW-1:0] hold_win [2];
  logic          hold_last [2];
  int            stall_cnt = 0;
  bit            stall_arm = 1'b0;
  bit            stall_now = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Each column keeps its last K pixels; a window is the K most recent columns of the row.
  task automatic model_accept(input logic [7:0] pix, input bit eol);
    logic [WW-1:0] w;
    exp_t          e;
    for (int r = 0; r < K - 1; r++) colhist[mcol][r] = colhist[mcol][r+1];
    colhist[mcol][K-1] = pix;
    for (int d = 0; d < 2; d++) begin
      if (mrow >= K - 1 && mcol >= K - 1 &&
          (mrow - (K - 1)) % (d + 1) == 0 && (mcol - (K - 1)) % (d + 1) == 0) begin
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++) w[(r*K+c)*W +: W] = colhist[mcol-(K-1)+c][r];
        e.win  = w;
        e.last = (mrow == D - 1) && (mcol == D - 1);
        e.cyc  = cyc;
        exp_q[d].push_back(e);
      end
    end
    if (EOL_EN && (eol != (mcol == D - 1)) && !exp_err) begin
      exp_err = 1'b1;
      err_cyc = cyc;
    end
    if (mrow == D - 1 && mcol == D - 1) begin
      mrow = 0;
      mcol = 0;
    end else if (mcol == D - 1 || (EOL_EN && eol)) begin
      mcol = 0;
      mrow++;
    end else begin
      mcol++;
    end
  endtask

  task automatic drive_mready(input int rpct);
    stall_now = 1'b0;
    if (stall_cnt > 0) begin
      bus.m_ready = 1'b0;
      stall_cnt--;
      stall_now = 1'b1;
    end else if (stall_arm && bus.m_valid) begin
      stall_arm   = 1'b0;
      stall_cnt   = 9;
      bus.m_ready = 1'b0;
      stall_now   = 1'b1;
    end else begin
      bus.m_ready = (int'($urandom_range(99)) < rpct);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] pix, input bit eol, input int rpct,
                      output bit acc);
    @(negedge clk);
    bus.s_valid = v;
    bus.s_data  = pix;
`ifdef CONV_LB_EOL_CHECK_EN
    bus.s_eol   = eol;
`endif
    drive_mready(rpct);
    #1;
    if (stall_now) chk("stall_s_ready", bus.s_ready, 1'b0);
    acc = v && bus.s_ready;
    if (acc) model_accept(pix, eol);
  endtask

  task automatic send_pixel(input logic [7:0] pix, input bit eol, input int vpct, input int rpct);
    bit acc;
    int n;
    while (int'($urandom_range(99)) >= vpct) step(1'b0, '0, 1'b0, rpct, acc);
    n   = 0;
    acc = 1'b0;
    while (!acc) begin
      if (n == 1000) begin
        errors++;
        $display("FAIL accept_timeout actual=stalled expected=accepted");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "input stalled");
      end
      step(1'b1, pix, eol, rpct, acc);
      n++;
    end
  endtask

  // mode 0: row*32+col pattern, 1: pattern XOR 0xFF, 2: random pixels.
  task automatic send_frame(input int mode, input int vpct, input int rpct, input int maxpix,
                            input bit inject);
    int         n;
    logic [7:0] pix;
    bit         eol;
    n = 0;
    do begin
      pix = 8'((mrow * 32 + mcol) & 255);
      if (mode == 1) pix = pix ^ 8'hFF;
      if (mode == 2) pix = 8'($urandom);
      eol = (mcol == D - 1) || (inject && mrow == 0 && mcol == 20);
      send_pixel(pix, eol, vpct, rpct);
      n++;
    end while (n < maxpix && !(mrow == 0 && mcol == 0));
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while ((exp_q[0].size() > 0 || exp_q[1].size() > 0) && n < 300) begin
      step(1'b0, '0, 1'b0, 100, acc);
      n++;
    end
    chk("drain_empty", exp_q[0].size() + exp_q[1].size(), 0);
  endtask

  task automatic check_counts(input int frames);
    chk("frame_windows_s1", popped[0], frames * ((D - K) / 1 + 1) * ((D - K) / 1 + 1));
    chk("frame_windows_s2", popped[1], frames * ((D - K) / 2 + 1) * ((D - K) / 2 + 1));
    popped[0] = 0;
    popped[1] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.s_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_m_valid_s1", bus.m_valid, 1'b0);
    chk("rst_m_valid_s2", bus2.m_valid, 1'b0);
    chk("rst_m_last_s1", bus.m_last, 1'b0);
    chk("rst_m_window_s1", bus.m_window, '0);
`ifdef CONV_LB_EOL_CHECK_EN
    chk("rst_o_err", bus.o_err, 1'b0);
`endif
    exp_q[0].delete();
    exp_q[1].delete();
    hold[0]   = 1'b0;
    hold[1]   = 1'b0;
    mrow      = 0;
    mcol      = 0;
    popped[0] = 0;
    popped[1] = 0;
    exp_err   = 1'b0;
    stall_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      #3;
      if (rst_n) begin
        for (int d = 0; d < 2; d++) begin
          logic          mv, mr, sr, ml;
          logic [WW-1:0] mw;
          exp_t          e;
          mv = (d == 0) ? bus.m_valid  : bus2.m_valid;
          mr = (d == 0) ? bus.m_ready  : bus2.m_ready;
          sr = (d == 0) ? bus.s_ready  : bus2.s_ready;
          ml = (d == 0) ? bus.m_last   : bus2.m_last;
          mw = (d == 0) ? bus.m_window : bus2.m_window;
          if (hold[d]) begin
            chk((d == 0) ? "hold_valid_s1"  : "hold_valid_s2",  mv, 1'b1);
            chk((d == 0) ? "hold_window_s1" : "hold_window_s2", mw, hold_win[d]);
            chk((d == 0) ? "hold_last_s1"   : "hold_last_s2",   ml, hold_last[d]);
          end
          chk((d == 0) ? "s_ready_s1" : "s_ready_s2", sr, !mv || mr);
          hold[d]      = mv && !mr;
          hold_win[d]  = mw;
          hold_last[d] = ml;
          if (mv && mr) begin
            if (exp_q[d].size() == 0 || exp_q[d][0].cyc >= cyc) begin
              checks++;
              errors++;
              $display("FAIL unexpected_window_s%0d actual=valid expected=none window=%0h",
                       d + 1, mw);
            end else begin
              e = exp_q[d].pop_front();
              chk((d == 0) ? "window_s1" : "window_s2", mw, e.win);
              chk((d == 0) ? "last_s1"   : "last_s2",   ml, e.last);
              popped[d]++;
            end
          end else if (exp_q[d].size() > 0 && exp_q[d][0].cyc < cyc) begin
            chk((d == 0) ? "latency_valid_s1" : "latency_valid_s2", mv, 1'b1);
          end
        end
`ifdef CONV_LB_EOL_CHECK_EN
        chk("o_err_s1", bus.o_err,  exp_err && (cyc > err_cyc));
        chk("o_err_s2", bus2.o_err, exp_err && (cyc > err_cyc));
`endif
      end else begin
        hold[0] = 1'b0;
        hold[1] = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    errors++;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin : driver
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
`ifdef CONV_LB_EOL_CHECK_EN
    bus.s_eol   = 1'b0;
`endif
    popped[0] = 0;
    popped[1] = 0;
    hold[0]   = 1'b0;
    hold[1]   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("init_m_valid_s1",  bus.m_valid,   1'b0);
    chk("init_m_valid_s2",  bus2.m_valid,  1'b0);
    chk("init_m_last_s1",   bus.m_last,    1'b0);
    chk("init_m_window_s1", bus.m_window,  '0);
    chk("init_m_window_s2", bus2.m_window, '0);
    chk("init_s_ready_s1",  bus.s_ready,   1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Two back-to-back frames at full throughput, the second inverted.
    send_frame(0, 100, 100, 100000, 1'b0);
    send_frame(1, 100, 100, 100000, 1'b0);
    drain();
    check_counts(2);

    // Random gaps and backpressure with one forced 10-cycle stall.
    stall_arm = 1'b1;
    send_frame(0, 80, 70, 100000, 1'b0);
    drain();
    check_counts(1);

    // Partial frame dropped by reset, then a clean random frame.
    send_frame(2, 90, 80, 100, 1'b0);
    do_reset();
    send_frame(2, 90, 80, 100000, 1'b0);
    drain();
    check_counts(1);

`ifdef CONV_LB_EOL_CHECK_EN
    // Early end-of-line at (0,20): row resyncs and o_err latches.
    send_frame(0, 100, 100, 100000, 1'b1);
    drain();
    chk("o_err_sticky", bus.o_err, 1'b1);
    popped[0] = 0;
    popped[1] = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_line_buffer.md
Name: conv_line_buffer

Overview:
Upstream feeder for the convolution window control stage. Accepts a raster-order pixel stream of a DATA_SIZE x DATA_SIZE image over a valid/ready handshake and buffers KERNEL_SIZE-1 rows in line memories. For every in-bounds, stride-aligned position it presents one registered KERNEL_SIZE x KERNEL_SIZE window with valid/ready backpressure, and flags the final window of each frame.

Parameters:
DATA_SIZE, 32, image width and height in pixels (square frame)
KERNEL_SIZE, 5, window edge length; must satisfy 2 <= KERNEL_SIZE <= DATA_SIZE
PIX_W, 8, bits per pixel
STRIDE, 1, window step in both row and column; must be >= 1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input pixel valid
s_ready  out  1  input pixel accepted when s_valid && s_ready
s_data  in  PIX_W  input pixel
m_valid  out  1  window valid
m_ready  in  1  downstream accepts window when m_valid && m_ready
m_window  out  KERNEL_SIZE*KERNEL_SIZE*PIX_W  flattened window; element (r,c) at bits [(r*KERNEL_SIZE+c)*PIX_W +: PIX_W]; r=0 is the oldest (top) row, c=0 is the leftmost column
m_last  out  1  qualifies m_valid; marks the window whose bottom-right pixel is (DATA_SIZE-1, DATA_SIZE-1)

Behaviour:
- Reset (asynchronous) clears row and col counters, m_valid, m_last and window registers to 0. Line memories are not reset.
- s_ready = !m_valid || m_ready. A single output stage gives full throughput, one pixel per cycle.
- Accept: s_valid && s_ready.
- On accept at (row, col), new window column, top to bottom:
  - line_mem[K-2][col], ..., line_mem[0][col], s_data.
  - The window shifts left one column and the new column enters at c = K-1.
  - line_mem[0][col] <= s_data; line_mem[k][col] <= line_mem[k-1][col].
- Window complete when all hold:
  - row >= K-1 and col >= K-1;
  - (row-(K-1)) % STRIDE == 0;
  - (col-(K-1)) % STRIDE == 0.
- Latency: m_valid rises the cycle after the accept of a completing pixel.
- m_valid clears on m_ready when the same-cycle accept does not complete a window. If it does complete one, m_valid stays 1 with new data.
- m_window and m_last stay stable while m_valid && !m_ready. s_ready is low in that condition, so no window shift can occur.
- Counter update:
  - col increments on each accept.
  - At col = DATA_SIZE-1: col <= 0 and row increments.
  - At (DATA_SIZE-1, DATA_SIZE-1): row and col both go to 0.
- No window straddles frames: row restarts at 0, so stale line contents are never emitted.
- Counter width: clog2(DATA_SIZE). Modulo-STRIDE checks use per-axis phase counters, not a divider.
- Reset mid-frame drops the partial frame. The next pixel after release is (0,0).
- Windows per frame: ((DATA_SIZE-K)/STRIDE+1)^2.

Optional Feature:
CONV_LB_EOL_CHECK_EN
- Defined: adds input s_eol (1 bit, sampled on accept) and output o_err (1 bit, sticky, reset 0).
  - Mismatch occurs when s_eol != (col == DATA_SIZE-1).
  - On mismatch, o_err is set.
  - If s_eol=1 early, col <= 0 and row increments (resync).
  - If s_eol=0 at the last column, normal wrap applies.
  - Window generation continues.
- Undefined: neither port exists and counters are purely count-based.

Decomposition:
- Package conv_pkg:
  - default DATA_SIZE, KERNEL_SIZE, PIX_W, STRIDE;
  - clog2 function;
  - window-index helper constant for (r,c) to bit offset, shared with the window control and MAC stages.
- Sub-module conv_line_mem: one DATA_SIZE-deep row delay, PIX_W wide, indexed by col. Read-before-write in the same cycle. Instantiate KERNEL_SIZE-1 times.

Test Plan:
1. Defaults, m_ready=1, full frame with pixel=(row*32+col)&0xFF:
   - exactly 784 windows;
   - first m_valid the cycle after accepting (4,4), with element(0,0)=0x00 and element(4,4)=0x84;
   - m_last only on window 784.
2. m_ready=0 for 10 cycles while m_valid=1:
   - s_ready=0 and m_window and m_last unchanged throughout;
   - after release, window count and contents match test 1 (no loss or duplication).
3. STRIDE=2:
   - 196 windows;
   - first window at (4,4), second at (4,6);
   - no window at (5,x).
4. Two frames back-to-back, second frame pixels XOR 0xFF:
   - 784 + 784 windows;
   - second frame's first m_valid after its (4,4), with element(0,0)=0xFF.
5. rst_n pulsed low after 100 pixels:
   - m_valid=0 immediately;
   - following full frame yields 784 windows, first at (4,4).
6. CONV_LB_EOL_CHECK_EN defined, s_eol=1 at (0,20):
   - o_err=1 next cycle and stays 1;
   - next pixel is counted as (1,0).
